// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types and width helpers for the programmable FIFO
package fifo_pkg;

  typedef enum logic {FIFO_STD, FIFO_FWFT} fifo_mode_e;

  function automatic int ptr_w(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

  function automatic int count_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - simple dual-port storage, sync write, async or registered read
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int         DWIDTH = 32,
  parameter int         DEPTH  = 32,
  parameter fifo_mode_e MODE   = FIFO_FWFT,
  parameter int         AW     = ptr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DWIDTH-1:0] rdata
);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [DWIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register is reset so the standard-mode output starts at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = (MODE == FIFO_FWFT) ? mem[raddr] : rdata_q;

endmodule

// File: rtl/fifo_sync_prog.sv
// rtl/fifo_sync_prog.sv - single-clock FIFO with FWFT/standard modes and thresholds
module fifo_sync_prog
  import fifo_pkg::*;
#(
  parameter int DWIDTH    = 32,
  parameter int DEPTH     = 32,
  parameter int FWFT      = 1,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int CW        = count_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic [DWIDTH-1:0] data_i,
  input  logic              wr,
  output logic              full_o,
  output logic              almost_full_o,
  output logic              overflow_o,
  output logic [DWIDTH-1:0] data_o,
  input  logic              rd,
  output logic              valid_o,
  output logic              empty_o,
  output logic              almost_empty_o,
  output logic              underflow_o,
  output logic [CW-1:0]     count_o
);

  localparam int         PW   = ptr_w(DEPTH);
  localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

  logic [PW-1:0]     wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic [CW-1:0]     count_q, count_n;
  logic              full_q, af_q, empty_q, ae_q, ovf_q, unf_q, rvalid_q;
  logic              ovf_n, unf_n, rvalid_n;
  logic              wr_acc, rd_acc;
  logic [DWIDTH-1:0] ram_rdata;

  // Acceptance looks only at registered flags, keeping rd/wr off the flag paths.
  assign wr_acc = wr && !full_q && !clr_i;
  assign rd_acc = rd && !empty_q && !clr_i;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    wr_ptr_n = wr_ptr;
    rd_ptr_n = rd_ptr;
    count_n  = count_q;
    ovf_n    = ovf_q | (wr & full_q);
    unf_n    = unf_q | (rd & empty_q);
    rvalid_n = rd_acc;
    if (clr_i) begin
      wr_ptr_n = '0;
      rd_ptr_n = '0;
      count_n  = '0;
      ovf_n    = 1'b0;
      unf_n    = 1'b0;
      rvalid_n = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_n = ptr_inc(wr_ptr);
      if (rd_acc) rd_ptr_n = ptr_inc(rd_ptr);
      case ({wr_acc, rd_acc})
        2'b10:   count_n = count_q + CW'(1);
        2'b01:   count_n = count_q - CW'(1);
        default: count_n = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      af_q     <= 1'b0;
      empty_q  <= 1'b1;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_n;
      rd_ptr   <= rd_ptr_n;
      count_q  <= count_n;
      full_q   <= (count_n == CW'(DEPTH));
      af_q     <= (count_n >= CW'(AF_THRESH));
      empty_q  <= (count_n == '0);
      ae_q     <= (count_n <= CW'(AE_THRESH));
      ovf_q    <= ovf_n;
      unf_q    <= unf_n;
      rvalid_q <= rvalid_n;
    end
  end

  fifo_ram #(
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH),
    .MODE   (MODE),
    .AW     (PW)
  ) u_ram (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (wr_acc),
    .waddr  (wr_ptr),
    .wdata  (data_i),
    .re     (rd_acc),
    .raddr  (rd_ptr),
    .rdata  (ram_rdata)
  );

  // FWFT output is forced to zero while empty so stale memory never shows.
  assign data_o         = (MODE == FIFO_FWFT) ? (empty_q ? {DWIDTH{1'b0}} : ram_rdata) : ram_rdata;
  assign valid_o        = (MODE == FIFO_FWFT) ? !empty_q : rvalid_q;
  assign full_o         = full_q;
  assign almost_full_o  = af_q;
  assign empty_o        = empty_q;
  assign almost_empty_o = ae_q;
  assign overflow_o     = ovf_q;
  assign underflow_o    = unf_q;
  assign count_o        = count_q;

endmodule

// File: tb/tb_fifo_sync_prog.sv
// tb/tb_fifo_sync_prog.sv - self-checking bench for FWFT and standard FIFO instances
module tb_fifo_sync_prog;

  localparam int DW = 8;
  localparam int DP = 5;
  localparam int CW = 3;
  localparam logic L = 1'b0;
  localparam logic H = 1'b1;

  logic clk = 1'b0;
  logic rst_n, clr, wr, rd;
  logic [DW-1:0] din;

  logic f_full, f_af, f_ovf, f_valid, f_empty, f_ae, f_unf;
  logic s_full, s_af, s_ovf, s_valid, s_empty, s_ae, s_unf;
  logic [DW-1:0] f_data, s_data;
  logic [CW-1:0] f_count, s_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fifo_sync_prog #(.DWIDTH(DW), .DEPTH(DP), .FWFT(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .clr_i(clr), .data_i(din), .wr(wr),
    .full_o(f_full), .almost_full_o(f_af), .overflow_o(f_ovf), .data_o(f_data),
    .rd(rd), .valid_o(f_valid), .empty_o(f_empty), .almost_empty_o(f_ae),
    .underflow_o(f_unf), .count_o(f_count)
  );

  fifo_sync_prog #(.DWIDTH(DW), .DEPTH(DP), .FWFT(0)) u_std (
    .clk(clk), .rst_n(rst_n), .clr_i(clr), .data_i(din), .wr(wr),
    .full_o(s_full), .almost_full_o(s_af), .overflow_o(s_ovf), .data_o(s_data),
    .rd(rd), .valid_o(s_valid), .empty_o(s_empty), .almost_empty_o(s_ae),
    .underflow_o(s_unf), .count_o(s_count)
  );

  typedef struct {
    logic          wr, rd, clr;
    logic [DW-1:0] din;
    int            cnt;
    logic          full, af, empty, ae, ovf, unf;
    logic [DW-1:0] fdata, sdata;
    logic          svalid;
  } vec_t;

  vec_t vecs[17];

  // Reference model: a plain queue of stored words plus sticky bits.
  logic [DW-1:0] mq[$];
  logic          m_ovf, m_unf, m_sv;
  logic [DW-1:0] m_sd;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_sv  = 1'b0;
    m_sd  = '0;
  endtask

  task automatic model_edge();
    logic was_full, was_empty;
    if (clr) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_sv  = 1'b0;
    end else begin
      was_full  = (mq.size() == DP);
      was_empty = (mq.size() == 0);
      if (wr && was_full) m_ovf = 1'b1;
      if (rd && was_empty) m_unf = 1'b1;
      m_sv = rd && !was_empty;
      if (rd && !was_empty) m_sd = mq.pop_front();
      if (wr && !was_full) mq.push_back(din);
    end
  endtask

  task automatic check_model(input string tag);
    int n;
    logic [DW-1:0] head;
    n = mq.size();
    head = (n > 0) ? mq[0] : '0;
    chk({tag, ".f_count"}, 32'(f_count), n);
    chk({tag, ".s_count"}, 32'(s_count), n);
    chk({tag, ".full"}, {30'd0, f_full, s_full}, {30'd0, n == DP, n == DP});
    chk({tag, ".af"}, {30'd0, f_af, s_af}, {30'd0, n >= 3, n >= 3});
    chk({tag, ".empty"}, {30'd0, f_empty, s_empty}, {30'd0, n == 0, n == 0});
    chk({tag, ".ae"}, {30'd0, f_ae, s_ae}, {30'd0, n <= 2, n <= 2});
    chk({tag, ".ovf"}, {30'd0, f_ovf, s_ovf}, {30'd0, m_ovf, m_ovf});
    chk({tag, ".unf"}, {30'd0, f_unf, s_unf}, {30'd0, m_unf, m_unf});
    chk({tag, ".f_data"}, 32'(f_data), 32'(head));
    chk({tag, ".f_valid"}, 32'(f_valid), 32'(n != 0));
    chk({tag, ".s_data"}, 32'(s_data), 32'(m_sd));
    chk({tag, ".s_valid"}, 32'(s_valid), 32'(m_sv));
  endtask

  task automatic step(input logic w, input logic r, input logic c, input logic [DW-1:0] d);
    wr  = w;
    rd  = r;
    clr = c;
    din = d;
    @(posedge clk);
    #1;
    model_edge();
  endtask

  initial begin
    vecs[0]  = '{H,L,L,8'h11, 1, L,L,L,H,L,L, 8'h11,8'h00,L};
    vecs[1]  = '{H,L,L,8'h22, 2, L,L,L,H,L,L, 8'h11,8'h00,L};
    vecs[2]  = '{H,L,L,8'h33, 3, L,H,L,L,L,L, 8'h11,8'h00,L};
    vecs[3]  = '{H,L,L,8'h44, 4, L,H,L,L,L,L, 8'h11,8'h00,L};
    vecs[4]  = '{H,L,L,8'h55, 5, H,H,L,L,L,L, 8'h11,8'h00,L};
    vecs[5]  = '{H,L,L,8'h66, 5, H,H,L,L,H,L, 8'h11,8'h00,L};
    vecs[6]  = '{L,H,L,8'h00, 4, L,H,L,L,H,L, 8'h22,8'h11,H};
    vecs[7]  = '{L,H,L,8'h00, 3, L,H,L,L,H,L, 8'h33,8'h22,H};
    vecs[8]  = '{L,H,L,8'h00, 2, L,L,L,H,H,L, 8'h44,8'h33,H};
    vecs[9]  = '{L,H,L,8'h00, 1, L,L,L,H,H,L, 8'h55,8'h44,H};
    vecs[10] = '{L,H,L,8'h00, 0, L,L,H,H,H,L, 8'h00,8'h55,H};
    vecs[11] = '{L,H,L,8'h00, 0, L,L,H,H,H,H, 8'h00,8'h55,L};
    vecs[12] = '{L,H,L,8'h00, 0, L,L,H,H,H,H, 8'h00,8'h55,L};
    vecs[13] = '{H,L,L,8'hAA, 1, L,L,L,H,H,H, 8'hAA,8'h55,L};
    vecs[14] = '{H,L,L,8'hBB, 2, L,L,L,H,H,H, 8'hAA,8'h55,L};
    vecs[15] = '{H,L,L,8'hCC, 3, L,H,L,L,H,H, 8'hAA,8'h55,L};
    vecs[16] = '{H,L,H,8'hDD, 0, L,L,H,H,L,L, 8'h00,8'h55,L};

    rst_n = 1'b0;
    wr = 1'b0; rd = 1'b0; clr = 1'b0; din = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_model("reset");
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].wr, vecs[i].rd, vecs[i].clr, vecs[i].din);
      chk($sformatf("vec%0d.count", i), {13'd0, f_count, 13'd0, s_count},
          {13'd0, CW'(vecs[i].cnt), 13'd0, CW'(vecs[i].cnt)});
      chk($sformatf("vec%0d.flags", i), {f_full, f_af, f_empty, f_ae, f_ovf, f_unf},
          {vecs[i].full, vecs[i].af, vecs[i].empty, vecs[i].ae, vecs[i].ovf, vecs[i].unf});
      chk($sformatf("vec%0d.sflags", i), {s_full, s_af, s_empty, s_ae, s_ovf, s_unf},
          {vecs[i].full, vecs[i].af, vecs[i].empty, vecs[i].ae, vecs[i].ovf, vecs[i].unf});
      chk($sformatf("vec%0d.fdata", i), {f_data, 7'd0, f_valid},
          {vecs[i].fdata, 7'd0, !vecs[i].empty});
      chk($sformatf("vec%0d.sdata", i), {s_data, 7'd0, s_valid},
          {vecs[i].sdata, 7'd0, vecs[i].svalid});
    end

    for (int i = 0; i < 12; i++) begin
      step(H, L, L, 8'(i * 7 + 1));
      check_model($sformatf("wrap_wr%0d", i));
      step(L, H, L, 8'h00);
      check_model($sformatf("wrap_rd%0d", i));
      chk($sformatf("wrap_sdata%0d", i), 32'(s_data), 32'(i * 7 + 1));
    end

    step(H, L, L, 8'h21);
    step(H, L, L, 8'h22);
    step(H, H, L, 8'h23);
    check_model("wrrd");
    chk("wrrd_count", 32'(f_count), 32'd2);

    step(H, L, L, 8'h24);
    step(H, L, L, 8'h25);
    chk("pre_rst_count", 32'(f_count), 32'd4);
    wr = 1'b1;
    din = 8'h26;
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_model("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_model("rst_hold");

    step(H, L, L, 8'hA5);
    chk("fwft_a5", {f_data, 7'd0, f_empty}, {8'hA5, 8'h00});
    step(L, H, L, 8'h00);
    chk("std_a5", {s_data, 7'd0, s_valid}, {8'hA5, 8'h01});
    check_model("a5");

    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 50),
           1'($urandom_range(0, 49) == 0), 8'($urandom));
      check_model($sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
